// File: rtl/conv_loop_controller.sv
// conv_loop_controller: nested-loop sequencer driving a convolution MAC datapath with a partial-sum memory
module conv_loop_controller #(
  parameter int ADDR_W = 20,
  parameter int DIM_W = 16,
  parameter int KERNEL_SIZE = 3,
  parameter int MAC_LATENCY = 5
) (
  input  logic              clk,
  input  logic              arst_in,
  input  logic              start,
  input  logic [DIM_W-1:0]  cfg_width,
  input  logic [DIM_W-1:0]  cfg_height,
  input  logic [DIM_W-1:0]  cfg_ch_in,
  input  logic [DIM_W-1:0]  cfg_ch_out,
  output logic              running,
  output logic              cfg_error,
  input  logic              valid,
  output logic              ready,
  output logic              write_a,
  output logic              write_b,
  output logic              mac_valid,
  output logic              mac_accumulate_with_0,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_read_addr,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_write_addr,
  output logic              output_valid,
  output logic [DIM_W-1:0]  output_x,
  output logic [DIM_W-1:0]  output_y,
  output logic [DIM_W-1:0]  output_ch,
  output logic              done
);
  localparam int KW = KERNEL_SIZE > 1 ? $clog2(KERNEL_SIZE) : 1;
  localparam int LW = MAC_LATENCY > 1 ? $clog2(MAC_LATENCY) : 1;
  localparam int L = MAC_LATENCY - 1;
  typedef enum logic [1:0] {IDLE, MAC, DRAIN, DONE} state_t;
  state_t state;
  logic [DIM_W-1:0] w_q, h_q, ci_q, co_q, x, y, ci, co;
  logic [KW-1:0] kx, ky;
  logic [ADDR_W-1:0] pt;
  logic [LW-1:0] drain_cnt;
  logic [MAC_LATENCY-1:0] pv, pf;
  logic [ADDR_W-1:0] pa [MAC_LATENCY];
  logic [DIM_W-1:0] px [MAC_LATENCY];
  logic [DIM_W-1:0] py [MAC_LATENCY];
  logic [DIM_W-1:0] pc [MAC_LATENCY];
  logic fire, tap0, kx_last, ky_last, tap_last, co_last, x_last, y_last, ci_last, pass_end, bad_cfg;
  assign ready = state == MAC;
  assign running = state != IDLE;
  assign done = state == DONE;
  assign fire = valid && ready;
  assign kx_last = kx == KW'(KERNEL_SIZE - 1);
  assign ky_last = ky == KW'(KERNEL_SIZE - 1);
  assign tap0 = kx == '0 && ky == '0;
  assign tap_last = kx_last && ky_last;
  assign co_last = co == co_q - 1'b1;
  assign x_last = x == w_q - 1'b1;
  assign y_last = y == h_q - 1'b1;
  assign ci_last = ci == ci_q - 1'b1;
  assign pass_end = tap_last && co_last && x_last && y_last;
  assign bad_cfg = cfg_width == '0 || cfg_height == '0 || cfg_ch_in == '0 || cfg_ch_out == '0;
  assign write_a = fire;
  assign write_b = fire;
  assign mac_valid = fire;
  assign mac_accumulate_with_0 = fire && tap0 && ci == '0;
  assign mem_re = fire && tap0 && ci != '0;
  assign mem_read_addr = mem_re ? pt : '0;
  assign output_valid = pv[L] && pf[L];
  assign mem_we = pv[L] && !pf[L];
  assign mem_write_addr = mem_we ? pa[L] : '0;
  assign output_x = output_valid ? px[L] : '0;
  assign output_y = output_valid ? py[L] : '0;
  assign output_ch = output_valid ? pc[L] : '0;
  // control FSM, config latch and the six loop counters (ch_in > y > x > ch_out > ky > kx)
  always_ff @(posedge clk or posedge arst_in) begin
    if (arst_in) begin
      state <= IDLE;
      cfg_error <= 1'b0;
      {w_q, h_q, ci_q, co_q} <= '0;
      {x, y, ci, co} <= '0;
      kx <= '0;
      ky <= '0;
      pt <= '0;
      drain_cnt <= '0;
    end else begin
      cfg_error <= 1'b0;
      case (state)
        IDLE: if (start) begin
          if (bad_cfg) cfg_error <= 1'b1;
          else begin
            state <= MAC;
            {w_q, h_q, ci_q, co_q} <= {cfg_width, cfg_height, cfg_ch_in, cfg_ch_out};
            {x, y, ci, co} <= '0;
            kx <= '0;
            ky <= '0;
            pt <= '0;
          end
        end
        MAC: if (fire) begin
          kx <= kx_last ? '0 : kx + 1'b1;
          if (kx_last) ky <= ky_last ? '0 : ky + 1'b1;
          if (tap_last) co <= co_last ? '0 : co + 1'b1;
          if (tap_last && co_last) x <= x_last ? '0 : x + 1'b1;
          if (tap_last && co_last && x_last) y <= y_last ? '0 : y + 1'b1;
          if (pass_end) ci <= ci_last ? '0 : ci + 1'b1;
          pt <= pass_end ? '0 : tap_last ? pt + 1'b1 : pt;
          if (pass_end && ci_last) begin
            state <= DRAIN;
            drain_cnt <= '0;
          end
        end
        DRAIN: begin
          drain_cnt <= drain_cnt + 1'b1;
          if (drain_cnt == LW'(MAC_LATENCY - 1)) state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end
  // result pipeline mirroring the MAC latency; each last-tap beat carries its point and destination
  always_ff @(posedge clk or posedge arst_in) begin
    if (arst_in) begin
      pv <= '0;
      pf <= '0;
      for (int i = 0; i < MAC_LATENCY; i++) begin
        pa[i] <= '0;
        px[i] <= '0;
        py[i] <= '0;
        pc[i] <= '0;
      end
    end else begin
      pv[0] <= fire && tap_last;
      pf[0] <= ci_last;
      pa[0] <= pt;
      px[0] <= x;
      py[0] <= y;
      pc[0] <= co;
      for (int i = 1; i < MAC_LATENCY; i++) begin
        pv[i] <= pv[i-1];
        pf[i] <= pf[i-1];
        pa[i] <= pa[i-1];
        px[i] <= px[i-1];
        py[i] <= py[i-1];
        pc[i] <= pc[i-1];
      end
    end
  end
endmodule

// File: tb/tb_conv_loop_controller.sv
// tb_conv_loop_controller: layer table plus randomized runs checked against a loop-level reference model
module tb_conv_loop_controller;
  localparam int AW = 20, DW = 16, K = 3, LAT = 5;
  logic clk = 1'b0, arst_in = 1'b1, start = 1'b0, valid = 1'b0;
  logic [DW-1:0] cfg_width = '0, cfg_height = '0, cfg_ch_in = '0, cfg_ch_out = '0;
  logic running, cfg_error, ready, write_a, write_b, mac_valid, mac_accumulate_with_0;
  logic mem_re, mem_we, output_valid, done;
  logic [AW-1:0] mem_read_addr, mem_write_addr;
  logic [DW-1:0] output_x, output_y, output_ch;
  int n_vec = 0, n_bad = 0;

  conv_loop_controller #(.ADDR_W(AW), .DIM_W(DW), .KERNEL_SIZE(K), .MAC_LATENCY(LAT)) dut (
    .clk(clk), .arst_in(arst_in), .start(start),
    .cfg_width(cfg_width), .cfg_height(cfg_height), .cfg_ch_in(cfg_ch_in), .cfg_ch_out(cfg_ch_out),
    .running(running), .cfg_error(cfg_error), .valid(valid), .ready(ready),
    .write_a(write_a), .write_b(write_b), .mac_valid(mac_valid),
    .mac_accumulate_with_0(mac_accumulate_with_0), .mem_re(mem_re), .mem_read_addr(mem_read_addr),
    .mem_we(mem_we), .mem_write_addr(mem_write_addr), .output_valid(output_valid),
    .output_x(output_x), .output_y(output_y), .output_ch(output_ch), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic running, ready, wa, wb, mv, acc0, re;
    logic [AW-1:0] raddr;
    logic we;
    logic [AW-1:0] waddr;
    logic ov;
    logic [DW-1:0] ox, oy, och;
    logic done, err;
  } out_t;
  typedef struct {int acc0, re, raddr, lt, fin, x, y, o;} beat_t;
  typedef struct {int due, fin, addr, x, y, o;} ev_t;
  typedef struct {int w, h, ci, co, mode; bit mid; int beats, outs, wes;} vec_t;

  // addresses and coordinates are only meaningful while their strobe is expected
  function automatic out_t sample(input out_t e, input bit masked);
    out_t a;
    a.running = running; a.ready = ready; a.wa = write_a; a.wb = write_b; a.mv = mac_valid;
    a.acc0 = mac_accumulate_with_0; a.re = mem_re; a.we = mem_we; a.ov = output_valid;
    a.done = done; a.err = cfg_error;
    a.raddr = (!masked || e.re) ? mem_read_addr : '0;
    a.waddr = (!masked || e.we) ? mem_write_addr : '0;
    a.ox = (!masked || e.ov) ? output_x : '0;
    a.oy = (!masked || e.ov) ? output_y : '0;
    a.och = (!masked || e.ov) ? output_ch : '0;
    return a;
  endfunction

  task automatic chk(input string nm, input out_t got, input out_t exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, got, exp);
    end
  endtask

  task automatic chk_int(input string nm, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", nm, got, exp);
    end
  endtask

  task automatic run_layer(input int w, input int h, input int nci, input int nco, input int mode,
                           input bit mid, output int nb, output int nov, output int nwe);
    beat_t bq[$];
    ev_t evq[$];
    beat_t b;
    ev_t ev;
    out_t e;
    int cyc, bi, done_cyc;
    bit in_mac;
    for (int c = 0; c < nci; c++)
      for (int yy = 0; yy < h; yy++)
        for (int xx = 0; xx < w; xx++)
          for (int o = 0; o < nco; o++)
            for (int ky = 0; ky < K; ky++)
              for (int kx = 0; kx < K; kx++) begin
                b.acc0 = int'(ky == 0 && kx == 0 && c == 0);
                b.re = int'(ky == 0 && kx == 0 && c != 0);
                b.raddr = ((yy * w + xx) * nco + o) % (1 << AW);
                b.lt = int'(ky == K - 1 && kx == K - 1);
                b.fin = int'(c == nci - 1);
                b.x = xx; b.y = yy; b.o = o;
                bq.push_back(b);
              end
    nb = 0; nov = 0; nwe = 0;
    @(posedge clk); #1;
    start = 1'b1; valid = 1'b0;
    cfg_width = DW'(w); cfg_height = DW'(h); cfg_ch_in = DW'(nci); cfg_ch_out = DW'(nco);
    @(negedge clk);
    chk("start_cycle", sample('0, 1'b0), '0);
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0; bi = 0; in_mac = 1'b1; done_cyc = -1;
    forever begin
      valid = mode == 0 ? 1'b1 : mode == 1 ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
      if (mid && cyc == 10) begin
        start = 1'b1; cfg_width = 7; cfg_height = 7; cfg_ch_in = 7; cfg_ch_out = 0;
      end else start = 1'b0;
      @(negedge clk);
      e = '0;
      e.running = done_cyc < 0 || cyc <= done_cyc;
      e.ready = in_mac;
      if (in_mac && valid) begin
        b = bq[bi];
        bi++;
        e.wa = 1'b1; e.wb = 1'b1; e.mv = 1'b1;
        e.acc0 = b.acc0 != 0; e.re = b.re != 0;
        e.raddr = b.re != 0 ? AW'(b.raddr) : '0;
        if (b.lt != 0) begin
          ev.due = cyc + LAT; ev.fin = b.fin; ev.addr = b.raddr; ev.x = b.x; ev.y = b.y; ev.o = b.o;
          evq.push_back(ev);
        end
        if (bi == bq.size()) begin
          in_mac = 1'b0;
          done_cyc = cyc + LAT + 1;
        end
      end
      if (evq.size() > 0 && evq[0].due == cyc) begin
        ev = evq.pop_front();
        if (ev.fin != 0) begin
          e.ov = 1'b1; e.ox = DW'(ev.x); e.oy = DW'(ev.y); e.och = DW'(ev.o);
        end else begin
          e.we = 1'b1; e.waddr = AW'(ev.addr);
        end
      end
      e.done = cyc == done_cyc;
      chk($sformatf("layer_%0dx%0dx%0dx%0d_cyc%0d", w, h, nci, nco, cyc), sample(e, 1'b1), e);
      nb += int'(mac_valid); nov += int'(output_valid); nwe += int'(mem_we);
      if (cyc == done_cyc) break;
      if (cyc >= 4000) begin
        n_vec++; n_bad++;
        $display("FAIL layer_timeout: got no done after %0d cycles want done", cyc);
        break;
      end
      @(posedge clk); #1;
      cyc++;
    end
    @(posedge clk); #1;
    start = 1'b0; valid = 1'b0;
    @(negedge clk);
    chk("idle_after_done", sample('0, 1'b0), '0);
  endtask

  initial begin
    vec_t tbl[6];
    out_t e;
    int nb, nov, nwe, w, h, c, o;
    tbl[0] = '{2, 2, 1, 1, 0, 1'b0, 36, 4, 0};
    tbl[1] = '{1, 1, 2, 2, 0, 1'b0, 36, 2, 2};
    tbl[2] = '{2, 2, 1, 1, 1, 1'b1, 36, 4, 0};
    tbl[3] = '{3, 2, 2, 2, 2, 1'b0, 216, 12, 12};
    tbl[4] = '{1, 1, 1, 1, 0, 1'b0, 9, 1, 0};
    tbl[5] = '{2, 1, 3, 1, 2, 1'b0, 54, 2, 4};

    start = 1'b1; valid = 1'b1;
    cfg_width = 5; cfg_height = 5; cfg_ch_in = 5; cfg_ch_out = 5;
    #12 chk("reset_outputs", sample('0, 1'b0), '0);
    @(posedge clk); #3;
    chk("reset_held", sample('0, 1'b0), '0);
    @(posedge clk); #1;
    arst_in = 1'b0; start = 1'b0; valid = 1'b0;
    @(negedge clk);
    chk("after_reset_idle", sample('0, 1'b0), '0);

    for (int f = 0; f < 4; f++) begin
      @(posedge clk); #1;
      start = 1'b1;
      cfg_width = f == 0 ? 0 : 2; cfg_height = f == 1 ? 0 : 2;
      cfg_ch_in = f == 2 ? 0 : 2; cfg_ch_out = f == 3 ? 0 : 2;
      @(negedge clk);
      chk($sformatf("bad_cfg%0d_same_cycle", f), sample('0, 1'b0), '0);
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      e = '0; e.err = 1'b1;
      chk($sformatf("bad_cfg%0d_error_pulse", f), sample('0, 1'b0), e);
      @(posedge clk); #1;
      @(negedge clk);
      chk($sformatf("bad_cfg%0d_pulse_end", f), sample('0, 1'b0), '0);
    end

    foreach (tbl[i]) begin
      run_layer(tbl[i].w, tbl[i].h, tbl[i].ci, tbl[i].co, tbl[i].mode, tbl[i].mid, nb, nov, nwe);
      chk_int($sformatf("tbl%0d_beats", i), nb, tbl[i].beats);
      chk_int($sformatf("tbl%0d_outputs", i), nov, tbl[i].outs);
      chk_int($sformatf("tbl%0d_mem_we", i), nwe, tbl[i].wes);
    end

    @(posedge clk); #1;
    start = 1'b1; valid = 1'b1;
    cfg_width = 1; cfg_height = 1; cfg_ch_in = 1; cfg_ch_out = 1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #3;
    e = '0; e.running = 1'b1;
    chk("drain_before_reset", sample('0, 1'b0), e);
    arst_in = 1'b1;
    #1 chk("reset_in_drain", sample('0, 1'b0), '0);
    @(posedge clk); #1;
    arst_in = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk($sformatf("post_reset_quiet%0d", i), sample('0, 1'b0), '0);
    end
    valid = 1'b0;
    run_layer(2, 2, 1, 1, 0, 1'b0, nb, nov, nwe);
    chk_int("restart_beats", nb, 36);
    chk_int("restart_outputs", nov, 4);

    for (int r = 0; r < 4; r++) begin
      w = $urandom_range(1, 3); h = $urandom_range(1, 3);
      c = $urandom_range(1, 3); o = $urandom_range(1, 3);
      run_layer(w, h, c, o, 2, 1'b0, nb, nov, nwe);
      chk_int($sformatf("rand%0d_beats", r), nb, w * h * c * o * K * K);
      chk_int($sformatf("rand%0d_outputs", r), nov, w * h * o);
      chk_int($sformatf("rand%0d_mem_we", r), nwe, w * h * o * (c - 1));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/conv_loop_controller.md
CONV_LOOP_CONTROLLER -- requirements
Module: conv_loop_controller

Interface
REQ-001 Parameter ADDR_W, default 20: partial-sum memory address width.
REQ-002 Parameter DIM_W, default 16: width of every runtime dimension and coordinate.
REQ-003 Parameter KERNEL_SIZE, default 3: kernel taps per axis, >=1.
REQ-004 Parameter MAC_LATENCY, default 5: cycles from last-tap MAC beat to result availability, >=1.
REQ-005 clk  in  1  sole clock, rising edge.
REQ-006 arst_in  in  1  reset, asynchronous, active-high.
REQ-007 start  in  1  single-cycle request to begin a layer.
REQ-008 cfg_width, cfg_height, cfg_ch_in, cfg_ch_out  in  DIM_W each  layer dimensions, sampled on accepted start.
REQ-009 running  out  1  high in every state except IDLE.
REQ-010 cfg_error  out  1  one-cycle pulse when start is rejected.
REQ-011 valid  in  1  upstream has activation and weight for the current beat.
REQ-012 ready  out  1  controller can accept a beat.
REQ-013 write_a, write_b  out  1 each  capture activation and weight into the datapath.
REQ-014 mac_valid  out  1  datapath performs a MAC this cycle.
REQ-015 mac_accumulate_with_0  out  1  MAC starts from zero, not the accumulator or memory.
REQ-016 mem_re / mem_read_addr  out  1 / ADDR_W  partial-sum read strobe and address.
REQ-017 mem_we / mem_write_addr  out  1 / ADDR_W  partial-sum write strobe and address.
REQ-018 output_valid  out  1  final result present this cycle.
REQ-019 output_x, output_y, output_ch  out  DIM_W each  coordinates of the final result.
REQ-020 done  out  1  one-cycle pulse at layer completion.

Function
REQ-021 FSM states: IDLE, MAC, DRAIN, DONE.
REQ-022 IDLE->MAC on start when all cfg_* are nonzero; the config is latched and all counters are cleared.
REQ-023 In IDLE, start with any cfg_* equal to zero: cfg_error pulses the next cycle and the FSM stays in IDLE.
REQ-024 Outside IDLE, start is ignored and the latched config does not change.
REQ-025 ready=1 only in MAC; a beat fires when valid&&ready.
REQ-026 On a fired beat: write_a, write_b and mac_valid are 1 in the same cycle; all three are 0 otherwise.
REQ-027 Loop order, outer to inner: ch_in, y, x, ch_out, ky, kx.
REQ-028 Each counter advances on a fired beat when every inner counter is at its last value, and wraps to 0 after its last value.
REQ-029 mac_accumulate_with_0=1 on a fired beat at tap (0,0) with ch_in==0.
REQ-030 mem_re=1 on a fired beat at tap (0,0) with ch_in!=0.
REQ-031 mem_read_addr = point index: a counter cleared at each ch_in pass start, incremented after every last-tap beat, and taken modulo 2^ADDR_W.
REQ-032 A last-tap beat (kx=ky=KERNEL_SIZE-1) enters a MAC_LATENCY-deep pipeline carrying the point index, x, y, ch_out and a final flag (ch_in==last).
REQ-033 At pipeline exit, a final entry drives output_valid=1 and output_x/y/ch; a non-final entry drives mem_we=1 with mem_write_addr = point index.
REQ-034 output_valid and mem_we are never high in the same cycle.
REQ-035 MAC->DRAIN on the fired beat that completes all loops.
REQ-036 The FSM stays in DRAIN exactly MAC_LATENCY cycles, then enters DONE.
REQ-037 done=1 in DONE for one cycle, then IDLE.
REQ-038 valid without ready (outside MAC) is a no-op; no counter moves.
REQ-039 Dimension 1 on any axis: that counter is always last, and the last-beat logic still holds.
REQ-040 Coordinates are DIM_W wide; address arithmetic wraps silently at ADDR_W.

Reset
REQ-041 While arst_in=1: state is IDLE; all counters and pipeline valid bits are 0.
REQ-042 While arst_in=1: every output is 0, including addresses and coordinates.
REQ-043 Reset mid-operation discards in-flight pipeline entries, and no mem_we or output_valid follows it.

Verification
REQ-044 W=H=2, CI=1, CO=1, K=3, LAT=5, valid held high -> 36 beats; output_valid 4 times, first 5 cycles after beat 9, coordinates (0,0,0),(1,0,0),(0,1,0),(1,1,0); done 6 cycles after beat 36; never mem_we.
REQ-045 W=H=1, CI=2, CO=2, K=1 -> mem_we at addr 0, 1; mem_re at addr 0, 1 in pass 2; then output_valid for ch 0, 1.
REQ-046 valid toggling 1/0 every cycle -> beat count and results identical to REQ-044, and the timeline is stretched.
REQ-047 start with cfg_ch_out=0 -> cfg_error pulse, running stays 0; start mid-layer -> no effect.
REQ-048 arst_in asserted during DRAIN -> all outputs 0 immediately, no subsequent output_valid, and a restart executes cleanly.
